// File: rtl/minifloat_frame_accum_if.sv
// Sample/result handshake bundle for minifloat_frame_accum.
//   in_valid/in_ready/in_exp/in_mant/in_last : minifloat sample stream into the block
//   out_valid/out_ready/out_sum/out_count/out_ovf : one frame result out of the block
// master drives samples and consumes results; slave is the accumulator.
interface minifloat_frame_accum_if #(
  parameter int unsigned SUM_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_exp;
  logic [3:0]       in_mant;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [7:0]       out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_exp, in_mant, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_exp, in_mant, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/minifloat_frame_accum.sv
// Frame accumulator for 7-bit minifloat samples {exp[2:0], mant[3:0]}.
// Each accepted sample is decoded to its exact integer value and added into a
// saturating SUM_W-bit sum; a frame closes on in_last or after FRAME_LEN samples
// and its result is offered once on the out_* handshake.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of minifloat_frame_accum_if (sample input, frame result output)
module minifloat_frame_accum #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned SUM_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  minifloat_frame_accum_if.slave bus
);

  localparam int unsigned DEC_W = 11;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned ADD_W = SUM_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [DEC_W-1:0] dec_val_q, dec_val_d;
  logic             dec_v_q, dec_v_d;
  logic             dec_close_q, dec_close_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W-1:0] out_sum_q, out_sum_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             close_pending_q, close_pending_d;
  logic             in_ready_q, in_ready_d;

  logic             accept_c;
  logic             close_c;
  logic [DEC_W-1:0] dec_c;
  logic [ADD_W-1:0] add_c;
  logic             clamp_c;
  logic [SUM_W-1:0] sat_c;

  // Minifloat to integer: denormal range is the bare mantissa, otherwise hidden one shifted.
  always_comb begin
    if (bus.in_exp == 3'd0) begin
      dec_c = DEC_W'(bus.in_mant);
    end else begin
      dec_c = DEC_W'({1'b1, bus.in_mant}) << (bus.in_exp - 3'd1);
    end
  end

  // Saturating add of the stage-1 value into the running sum; carry out means clamp.
  always_comb begin
    add_c   = ADD_W'(sum_q) + ADD_W'(dec_val_q);
    clamp_c = add_c[SUM_W];
    sat_c   = clamp_c ? '1 : add_c[SUM_W-1:0];
  end

  assign accept_c = bus.in_valid && in_ready_q;
  assign close_c  = bus.in_last || (acc_cnt_q == LAST_IDX);

  // Next-state logic for both pipeline stages and the result FSM.
  always_comb begin
    state_d         = state_q;
    dec_val_d       = dec_val_q;
    dec_v_d         = 1'b0;
    dec_close_d     = dec_close_q;
    acc_cnt_d       = acc_cnt_q;
    cnt_d           = cnt_q;
    out_count_d     = out_count_q;
    sum_d           = sum_q;
    out_sum_d       = out_sum_q;
    ovf_d           = ovf_q;
    out_valid_d     = out_valid_q;
    close_pending_d = close_pending_q;

    if (accept_c) begin
      dec_val_d   = dec_c;
      dec_v_d     = 1'b1;
      dec_close_d = close_c;
      acc_cnt_d   = close_c ? '0 : acc_cnt_q + CNT_W'(1);
      if (close_c) begin
        close_pending_d = 1'b1;
      end
    end

    if (state_q == ST_ACCUM) begin
      if (dec_v_q) begin
        sum_d = sat_c;
        ovf_d = ovf_q | clamp_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (dec_close_q) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_count_d = cnt_q + CNT_W'(1);
          out_sum_d   = sat_c;
        end
      end
    end else begin
      // Result held until taken; clearing here opens the next frame.
      if (bus.out_ready) begin
        state_d         = ST_ACCUM;
        out_valid_d     = 1'b0;
        sum_d           = '0;
        cnt_d           = '0;
        ovf_d           = 1'b0;
        close_pending_d = 1'b0;
      end
    end

    // Registered form of (state == ACCUM) && !close_pending.
    in_ready_d = (state_d == ST_ACCUM) && !close_pending_d;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_ACCUM;
      dec_val_q       <= '0;
      dec_v_q         <= 1'b0;
      dec_close_q     <= 1'b0;
      acc_cnt_q       <= '0;
      cnt_q           <= '0;
      out_count_q     <= '0;
      sum_q           <= '0;
      out_sum_q       <= '0;
      ovf_q           <= 1'b0;
      out_valid_q     <= 1'b0;
      close_pending_q <= 1'b0;
      in_ready_q      <= 1'b1;
    end else begin
      state_q         <= state_d;
      dec_val_q       <= dec_val_d;
      dec_v_q         <= dec_v_d;
      dec_close_q     <= dec_close_d;
      acc_cnt_q       <= acc_cnt_d;
      cnt_q           <= cnt_d;
      out_count_q     <= out_count_d;
      sum_q           <= sum_d;
      out_sum_q       <= out_sum_d;
      ovf_q           <= ovf_d;
      out_valid_q     <= out_valid_d;
      close_pending_q <= close_pending_d;
      in_ready_q      <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_minifloat_frame_accum.sv
// Bench for minifloat_frame_accum: a 16-bit and a 12-bit instance share one
// stimulus stream, so every frame is checked for both sum widths.
module tb_minifloat_frame_accum;

  localparam int FL = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_last, out_ready;
  logic [2:0] in_exp;
  logic [3:0] in_mant;

  always #5 clk = ~clk;

  minifloat_frame_accum_if #(.SUM_W(16)) bus_a ();
  minifloat_frame_accum_if #(.SUM_W(12)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_exp    = in_exp;
  assign bus_a.in_mant   = in_mant;
  assign bus_a.in_last   = in_last;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_exp    = in_exp;
  assign bus_b.in_mant   = in_mant;
  assign bus_b.in_last   = in_last;
  assign bus_b.out_ready = out_ready;

  minifloat_frame_accum #(.FRAME_LEN(FL), .SUM_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  minifloat_frame_accum #(.FRAME_LEN(FL), .SUM_W(12)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint s16;
    longint s12;
    int     cnt;
    bit     o16;
    bit     o12;
    int     avail;
  } res_t;

  int   cur_vals[$];
  res_t expq[$];
  bit   blocked = 1'b0;
  int   cyc = 0;
  bit   rdy, ev;

  function automatic int decode(input int e, input int m);
    if (e == 0) return m;
    return (16 + m) * (2 ** (e - 1));
  endfunction

  task automatic close_frame(input int edge_idx);
    res_t r;
    r.s16 = 0; r.s12 = 0; r.o16 = 0; r.o12 = 0;
    r.cnt = cur_vals.size();
    foreach (cur_vals[i]) begin
      r.s16 += cur_vals[i];
      if (r.s16 > 65535) begin r.s16 = 65535; r.o16 = 1; end
      r.s12 += cur_vals[i];
      if (r.s12 > 4095) begin r.s12 = 4095; r.o12 = 1; end
    end
    r.avail = edge_idx + 2;
    expq.push_back(r);
    cur_vals.delete();
    blocked = 1'b1;
  endtask

  // Scoreboard: judges readiness, result timing and contents at every edge.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      cur_vals.delete();
      expq.delete();
      blocked = 1'b0;
    end else begin
      rdy = !blocked;
      ev  = (expq.size() > 0) && (cyc >= expq[0].avail);
      chk("in_ready_a", bus_a.in_ready, rdy);
      chk("in_ready_b", bus_b.in_ready, rdy);
      chk("out_valid_a", bus_a.out_valid, ev);
      chk("out_valid_b", bus_b.out_valid, ev);
      if (ev) begin
        chk("sb_sum_a", bus_a.out_sum, expq[0].s16);
        chk("sb_ovf_a", bus_a.out_ovf, expq[0].o16);
        chk("sb_cnt_a", bus_a.out_count, expq[0].cnt);
        chk("sb_sum_b", bus_b.out_sum, expq[0].s12);
        chk("sb_ovf_b", bus_b.out_ovf, expq[0].o12);
        chk("sb_cnt_b", bus_b.out_count, expq[0].cnt);
        if (out_ready) begin
          void'(expq.pop_front());
          blocked = 1'b0;
        end
      end
      if (in_valid && rdy) begin
        cur_vals.push_back(decode(int'(in_exp), int'(in_mant)));
        if (in_last || cur_vals.size() == FL) close_frame(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int e, input int m, input bit last);
    int w = 0;
    in_valid = 1'b1;
    in_exp   = 3'(e);
    in_mant  = 4'(m);
    in_last  = last;
    while (bus_a.in_ready !== 1'b1 && w < 100) begin tick(); w++; end
    if (w >= 100) chk("send_timeout", w, 0);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the closing send: the result must appear one edge later.
  task automatic take_result(input string nm, input logic [63:0] s16, input logic [63:0] s12,
                             input logic [63:0] cnt, input bit o16, input bit o12);
    int w = 0;
    while (bus_a.out_valid !== 1'b1 && w < 40) begin tick(); w++; end
    chk({nm, "_latency"}, w, 1);
    chk({nm, "_sum16"}, bus_a.out_sum, s16);
    chk({nm, "_sum12"}, bus_b.out_sum, s12);
    chk({nm, "_cnt"}, bus_a.out_count, cnt);
    chk({nm, "_ovf16"}, bus_a.out_ovf, o16);
    chk({nm, "_ovf12"}, bus_b.out_ovf, o12);
  endtask

  typedef struct {
    int     e;
    int     m;
    int     n;
    bit     last;
    longint s16;
    longint s12;
    bit     o16;
    bit     o12;
  } vec_t;

  vec_t vt[12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{7, 15, 16, 1'b0, 31744, 4095, 1'b0, 1'b1};
    vt[1]  = '{0,  1,  1, 1'b1,     1,    1, 1'b0, 1'b0};
    vt[2]  = '{2, 15, 16, 1'b0,   992,  992, 1'b0, 1'b0};
    vt[3]  = '{7, 15,  3, 1'b1,  5952, 4095, 1'b0, 1'b1};
    vt[4]  = '{0,  1,  1, 1'b1,     1,    1, 1'b0, 1'b0};
    vt[5]  = '{0,  0,  2, 1'b1,     0,    0, 1'b0, 1'b0};
    vt[6]  = '{3,  2,  5, 1'b1,   360,  360, 1'b0, 1'b0};
    vt[7]  = '{1,  0, 16, 1'b0,   256,  256, 1'b0, 1'b0};
    vt[8]  = '{7, 15, 16, 1'b1, 31744, 4095, 1'b0, 1'b1};
    vt[9]  = '{6,  9,  4, 1'b1,  3200, 3200, 1'b0, 1'b0};
    vt[10] = '{6,  9,  6, 1'b1,  4800, 4095, 1'b0, 1'b1};
    vt[11] = '{5,  7, 16, 1'b0,  5888, 4095, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("rst_in_ready", bus_a.in_ready, 1);
    chk("rst_out_valid", bus_a.out_valid, 0);
    chk("rst_out_sum", bus_a.out_sum, 0);
    chk("rst_out_count", bus_a.out_count, 0);
    chk("rst_out_ovf", bus_a.out_ovf, 0);

    // Uniform frames; odd entries get random bubbles between samples.
    foreach (vt[v]) begin
      for (int i = 0; i < vt[v].n; i++) begin
        send(vt[v].e, vt[v].m, vt[v].last && (i == vt[v].n - 1));
        if ((v % 2 == 1) && (i < vt[v].n - 1)) repeat ($urandom % 3) tick();
      end
      take_result($sformatf("vec%0d", v), vt[v].s16, vt[v].s12, vt[v].n, vt[v].o16, vt[v].o12);
      tick();
    end

    // Mixed-value frame, readiness around close and handshake.
    send(0, 5, 1'b0);
    send(3, 2, 1'b0);
    send(1, 0, 1'b1);
    chk("mix_ready_low", bus_a.in_ready, 0);
    take_result("mix", 93, 93, 3, 1'b0, 1'b0);
    chk("mix_ready_low_done", bus_a.in_ready, 0);
    tick();
    chk("mix_valid_cleared", bus_a.out_valid, 0);
    chk("mix_ready_back", bus_a.in_ready, 1);
    chk("mix_sum_hold", bus_a.out_sum, 93);
    chk("mix_cnt_hold", bus_a.out_count, 3);

    // Backpressure with a sample waiting upstream.
    out_ready = 1'b0;
    send(0, 3, 1'b0);
    send(0, 3, 1'b1);
    take_result("bp1", 6, 6, 2, 1'b0, 1'b0);
    in_valid = 1'b1; in_exp = 3'd0; in_mant = 4'd7; in_last = 1'b0;
    repeat (10) begin
      tick();
      chk("bp_ready_low", bus_a.in_ready, 0);
      chk("bp_valid_held", bus_a.out_valid, 1);
      chk("bp_sum_held", bus_a.out_sum, 6);
    end
    out_ready = 1'b1;
    send(0, 7, 1'b0);
    send(0, 7, 1'b1);
    take_result("bp2", 14, 14, 2, 1'b0, 1'b0);
    tick();

    // Reset in the middle of a frame discards it.
    repeat (7) send(0, 9, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus_a.out_valid, 0);
    chk("mid_rst_ready", bus_a.in_ready, 1);
    chk("mid_rst_sum", bus_a.out_sum, 0);
    chk("mid_rst_cnt", bus_a.out_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_no_output", bus_a.out_valid, 0);
    repeat (16) send(0, 1, 1'b0);
    take_result("rst_fresh", 16, 16, 16, 1'b0, 1'b0);
    tick();

    // Random traffic against the scoreboard.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom % 3) != 0;
      in_exp    = 3'($urandom);
      in_mant   = 4'($urandom);
      in_last   = ($urandom % 10) == 0;
      out_ready = ($urandom % 4) != 0;
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (10) tick();
    chk("drain_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
